// File: rtl/stream_packetizer.sv
// stream_packetizer: buffers single-beat Avalon-ST words in a small FIFO and
// re-emits them as fixed-length packets with sop/eop framing for the mSGDMA
// stream-to-memory writer. Reports sink back-pressure cycles in stall_cnt.
// Optional feature: define STREAM_PKT_SEQ_CHECK_EN to count breaks in the
// incrementing counter sequence (seq_err_cnt); otherwise seq_err_cnt is 0.
module stream_packetizer #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_LEN    = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             snk_data,
  input  logic                          snk_valid,
  output logic                          snk_ready,
  input  logic                          snk_sop,
  input  logic                          snk_eop,
  output logic [DATA_W-1:0]             src_data,
  output logic                          src_valid,
  input  logic                          src_ready,
  output logic                          src_sop,
  output logic                          src_eop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   stall_cnt,
  output logic [15:0]                   seq_err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(PKT_LEN);

  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(PKT_LEN - 1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic [LW-1:0]     level_nxt;
  logic              full_q;
  logic              empty_q;
  logic [BW-1:0]     beat_cnt;
  logic              push;
  logic              pop;

  // Upstream framing is deliberately discarded; packets are re-framed here.
  logic unused_snk_framing;
  assign unused_snk_framing = snk_sop ^ snk_eop;

  // Handshakes come straight off registered flags: no same-cycle bypass,
  // so a full FIFO refuses input even while it is being popped.
  assign snk_ready  = !full_q;
  assign src_valid  = !empty_q;
  assign push       = snk_valid && snk_ready;
  assign pop        = src_valid && src_ready;
  assign src_data   = mem[rd_ptr];
  assign src_sop    = src_valid && (beat_cnt == '0);
  assign src_eop    = src_valid && (beat_cnt == BEAT_LAST);
  assign fifo_level = level;

  // Next occupancy: +1 on push only, -1 on pop only, unchanged on both.
  always_comb begin
    // NOTE: default assigned first so every path drives level_nxt (no latch).
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + 1'b1;
    end else if (pop && !push) begin
      level_nxt = level - 1'b1;
    end
  end

  // Storage array write; contents are qualified by the pointers/level.
  always_ff @(posedge clk) begin
    // NOTE: the data array is not reset; flushing the pointers and level is
    // enough, and an unreset array maps onto plain RAM.
    if (push) begin
      mem[wr_ptr] <= snk_data;
    end
  end

  // Pointers, occupancy and the registered full/empty flags.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level   <= level_nxt;
      full_q  <= (level_nxt == LEVEL_FULL);
      empty_q <= (level_nxt == '0);
    end
  end

  // Beat position within the current output packet; advances only on pops,
  // so an empty FIFO mid-packet stalls output without breaking framing.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (pop) begin
      if (beat_cnt == BEAT_LAST) beat_cnt <= '0;
      else                       beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Saturating count of cycles where the source was held off.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (snk_valid && !snk_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

`ifdef STREAM_PKT_SEQ_CHECK_EN
  logic [DATA_W-1:0] seq_expected;
  logic              seq_seen;
  logic [15:0]       seq_err_q;

  assign seq_err_cnt = seq_err_q;

  // Counter-sequence checker: each accepted word should be previous + 1;
  // on a mismatch count it and resynchronise to the received value.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_expected <= '0;
      seq_seen     <= 1'b0;
      seq_err_q    <= '0;
    end else if (push) begin
      seq_expected <= snk_data + 1'b1;
      seq_seen     <= 1'b1;
      if (seq_seen && (snk_data != seq_expected) && (seq_err_q != 16'hFFFF)) begin
        seq_err_q <= seq_err_q + 1'b1;
      end
    end
  end
`else
  assign seq_err_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_packetizer.sv
// Directed self-checking bench for stream_packetizer (PKT_LEN=4, depth 16).
// Expects seq_err_cnt=2 in the sequence test when STREAM_PKT_SEQ_CHECK_EN
// is defined, 0 otherwise.
module tb_stream_packetizer;

  localparam int DATA_W     = 64;
  localparam int FIFO_DEPTH = 16;
  localparam int PKT_LEN    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] snk_data;
  logic              snk_valid;
  logic              snk_ready;
  logic              snk_sop;
  logic              snk_eop;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_sop;
  logic              src_eop;
  logic [4:0]        fifo_level;
  logic [15:0]       stall_cnt;
  logic [15:0]       seq_err_cnt;

  int checks   = 0;
  int failures = 0;

  stream_packetizer #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .PKT_LEN   (PKT_LEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .snk_data   (snk_data),
    .snk_valid  (snk_valid),
    .snk_ready  (snk_ready),
    .snk_sop    (snk_sop),
    .snk_eop    (snk_eop),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_sop    (src_sop),
    .src_eop    (src_eop),
    .fifo_level (fifo_level),
    .stall_cnt  (stall_cnt),
    .seq_err_cnt(seq_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    snk_valid = 1'b0;
    src_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  int pushes;
  int exp_idx;
  int tx;
  int rx;
  bit push_now;
  bit pop_now;
  logic [63:0] seq_words [6];
  logic [15:0] seq_exp;

  initial begin
    reset     = 1'b1;
    snk_data  = '0;
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    src_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // ---- Reset values ----
    check("rst_snk_ready", 64'(snk_ready), 64'd1);
    check("rst_src_valid", 64'(src_valid), 64'd0);
    check("rst_src_sop",   64'(src_sop),   64'd0);
    check("rst_src_eop",   64'(src_eop),   64'd0);
    check("rst_level",     64'(fifo_level), 64'd0);
    check("rst_stall",     64'(stall_cnt), 64'd0);
    check("rst_seq_err",   64'(seq_err_cnt), 64'd0);

    // ---- Reset mid-stream ----
    snk_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      snk_data = 64'(100 + i);
      tick();
    end
    check("mid_level_before", 64'(fifo_level), 64'd5);
    do_reset();
    check("mid_level",     64'(fifo_level), 64'd0);
    check("mid_src_valid", 64'(src_valid), 64'd0);
    check("mid_snk_ready", 64'(snk_ready), 64'd1);
    check("mid_stall",     64'(stall_cnt), 64'd0);
    check("mid_seq_err",   64'(seq_err_cnt), 64'd0);
    snk_valid = 1'b1;
    snk_data  = 64'd200;
    tick();
    snk_valid = 1'b0;
    check("mid_first_valid", 64'(src_valid), 64'd1);
    check("mid_first_sop",   64'(src_sop),   64'd1);
    check("mid_first_data",  src_data,       64'd200);

    // ---- Framing: push 0..11 with src_ready=1 ----
    do_reset();
    src_ready = 1'b1;
    exp_idx   = 0;
    for (int c = 0; c < 20; c++) begin
      snk_valid = (c < 12);
      snk_data  = 64'(c);
      if (src_valid) begin
        check("frm_data", src_data, 64'(exp_idx));
        check("frm_sop",  64'(src_sop), 64'((exp_idx % PKT_LEN) == 0));
        check("frm_eop",  64'(src_eop), 64'((exp_idx % PKT_LEN) == PKT_LEN - 1));
        exp_idx++;
      end
      tick();
    end
    check("frm_count", 64'(exp_idx), 64'd12);

    // ---- Full: src_ready=0, snk_valid high for 20 cycles ----
    do_reset();
    snk_valid = 1'b1;
    pushes    = 0;
    for (int c = 0; c < 20; c++) begin
      snk_data = 64'(c);
      check("full_snk_ready", 64'(snk_ready), 64'(c < 16));
      if (snk_ready) pushes++;
      tick();
    end
    snk_valid = 1'b0;
    check("full_pushes", 64'(pushes), 64'd16);
    check("full_stall",  64'(stall_cnt), 64'd4);
    check("full_level",  64'(fifo_level), 64'd16);
    check("full_head",   src_data, 64'd0);
    src_ready = 1'b1;
    tick();
    src_ready = 1'b0;
    check("full_reassert", 64'(snk_ready), 64'd1);
    check("full_level_15", 64'(fifo_level), 64'd15);

    // ---- Simultaneous push/pop at level 8 ----
    do_reset();
    snk_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      snk_data = 64'(i);
      tick();
    end
    check("sim_level_init", 64'(fifo_level), 64'd8);
    src_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      snk_data = 64'(8 + i);
      check("sim_pop_data", src_data, 64'(i));
      tick();
      check("sim_level", 64'(fifo_level), 64'd8);
    end
    snk_valid = 1'b0;
    src_ready = 1'b0;
    tick();
    // 10 pops from beat 0 leaves beat 2 of a 4-beat packet.
    check("sim_head",  src_data, 64'd10);
    check("sim_sop_b2", 64'(src_sop), 64'd0);
    check("sim_eop_b2", 64'(src_eop), 64'd0);
    src_ready = 1'b1;
    tick();
    check("sim_data_b3", src_data, 64'd11);
    check("sim_eop_b3",  64'(src_eop), 64'd1);
    tick();
    check("sim_data_b0", src_data, 64'd12);
    check("sim_sop_b0",  64'(src_sop), 64'd1);
    for (int i = 0; i < 6; i++) tick();
    check("sim_drained_level", 64'(fifo_level), 64'd0);
    check("sim_drained_valid", 64'(src_valid), 64'd0);

    // ---- Sequence check: 0,1,2,5,6,8 ----
    do_reset();
    seq_words[0] = 64'd0; seq_words[1] = 64'd1; seq_words[2] = 64'd2;
    seq_words[3] = 64'd5; seq_words[4] = 64'd6; seq_words[5] = 64'd8;
    snk_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      snk_data = seq_words[i];
      tick();
    end
    snk_valid = 1'b0;
`ifdef STREAM_PKT_SEQ_CHECK_EN
    seq_exp = 16'd2;
`else
    seq_exp = 16'd0;
`endif
    check("seq_err_cnt", 64'(seq_err_cnt), 64'(seq_exp));
    check("seq_level",   64'(fifo_level), 64'd6);

    // ---- Random src_ready, continuous input of 0..99 ----
    do_reset();
    tx = 0;
    rx = 0;
    for (int c = 0; c < 1000 && rx < 100; c++) begin
      src_ready = 1'($urandom_range(0, 1));
      snk_valid = (tx < 100);
      snk_data  = 64'(tx);
      push_now  = snk_valid && snk_ready;
      pop_now   = src_valid && src_ready;
      if (pop_now) begin
        check("rnd_data", src_data, 64'(rx));
        check("rnd_sop",  64'(src_sop), 64'((rx % PKT_LEN) == 0));
        check("rnd_eop",  64'(src_eop), 64'((rx % PKT_LEN) == PKT_LEN - 1));
      end
      tick();
      if (push_now) tx++;
      if (pop_now)  rx++;
    end
    snk_valid = 1'b0;
    src_ready = 1'b0;
    check("rnd_rx_count", 64'(rx), 64'd100);
    check("rnd_seq_err",  64'(seq_err_cnt), 64'd0);
    check("rnd_level",    64'(fifo_level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
